// File: rtl/l_control_pipe.sv
// l_control_pipe: opcode decoder with a valid/ready input, a registered output stage and a 2-entry skid buffer.
// Define L_CONTROL_PIPE_DUAL_DECODE_EN to add a redundant comparator-chain decoder and a sticky decode_mismatch flag.
module l_control_pipe #(
    parameter int IW     = 16,
    parameter int OPW    = 5,
    parameter int OP_LSB = 11,
    parameter int NOPS   = 32,
    parameter int CW     = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IW-1:0]   in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IW-1:0]   out_instr,
    output logic [NOPS-1:0] out_onehot,
    output logic            out_illegal,
    output logic [CW-1:0]   decode_count,
    output logic            decode_mismatch
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    function automatic logic [NOPS-1:0] decode_shift(input logic [OPW-1:0] op);
        logic [NOPS-1:0] r;
        r = '0;
        if (int'(op) < NOPS) r = NOPS'(1) << op;
        return r;
    endfunction

    state_t          state;
    logic            rdy_q;
    logic [CW-1:0]   count_q;

    logic [OPW-1:0]  op_p0;
    logic [NOPS-1:0] onehot_p0;
    logic            illegal_p0;
    logic            accept;
    logic            xfer;

    logic            vld_p1;
    logic [IW-1:0]   instr_p1;
    logic [NOPS-1:0] onehot_p1;
    logic            illegal_p1;

    logic [IW-1:0]   instr_p2;
    logic [NOPS-1:0] onehot_p2;
    logic            illegal_p2;

    // Stage p0: combinational decode of the incoming word
    assign op_p0      = in[OP_LSB +: OPW];
    assign onehot_p0  = decode_shift(op_p0);
    assign illegal_p0 = (int'(op_p0) >= NOPS);
    assign accept     = in_valid && rdy_q;
    assign xfer       = vld_p1 && out_ready;

    // Stage p1: output register and occupancy FSM; in_ready is its own flop
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            vld_p1     <= 1'b0;
            rdy_q      <= 1'b1;
            instr_p1   <= '0;
            onehot_p1  <= '0;
            illegal_p1 <= 1'b0;
            count_q    <= '0;
        end else begin
            if (accept) count_q <= count_q + CW'(1);
            case (state)
                EMPTY: begin
                    if (accept) begin
                        instr_p1   <= in;
                        onehot_p1  <= onehot_p0;
                        illegal_p1 <= illegal_p0;
                        vld_p1     <= 1'b1;
                        state      <= ONE;
                    end
                end
                ONE: begin
                    if (accept && xfer) begin
                        instr_p1   <= in;
                        onehot_p1  <= onehot_p0;
                        illegal_p1 <= illegal_p0;
                    end else if (accept) begin
                        rdy_q <= 1'b0;
                        state <= TWO;
                    end else if (xfer) begin
                        vld_p1 <= 1'b0;
                        state  <= EMPTY;
                    end
                end
                TWO: begin
                    if (xfer) begin
                        instr_p1   <= instr_p2;
                        onehot_p1  <= onehot_p2;
                        illegal_p1 <= illegal_p2;
                        rdy_q      <= 1'b1;
                        state      <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Stage p2: skid entry, only meaningful while the FSM is in TWO
    always_ff @(posedge clk) begin
        if (state == ONE && accept && !xfer) begin
            instr_p2   <= in;
            onehot_p2  <= onehot_p0;
            illegal_p2 <= illegal_p0;
        end
    end

`ifdef L_CONTROL_PIPE_DUAL_DECODE_EN
    function automatic logic [NOPS-1:0] decode_cmp(input logic [OPW-1:0] op);
        logic [NOPS-1:0] r;
        r = '0;
        for (int k = 0; k < NOPS; k++) r[k] = (int'(op) == k);
        return r;
    endfunction

    logic [NOPS-1:0] onehot_alt_p0;
    logic            illegal_alt_p0;
    logic            mism_p0;
    logic            mism_q;

    assign onehot_alt_p0  = decode_cmp(op_p0);
    assign illegal_alt_p0 = ~|onehot_alt_p0;
    assign mism_p0        = (onehot_alt_p0 != onehot_p0) || (illegal_alt_p0 != illegal_p0);

    always_ff @(posedge clk) begin
        if (reset)                  mism_q <= 1'b0;
        else if (accept && mism_p0) mism_q <= 1'b1;
    end

    assign decode_mismatch = mism_q;
`else
    assign decode_mismatch = 1'b0;
`endif

    assign in_ready     = rdy_q;
    assign out_valid    = vld_p1;
    assign out_instr    = instr_p1;
    assign out_onehot   = onehot_p1;
    assign out_illegal  = illegal_p1;
    assign decode_count = count_q;

endmodule

// File: tb/tb_l_control_pipe.sv
// Scoreboard bench for l_control_pipe: a default instance and a NOPS=28/CW=4 instance share one stimulus stream.
module tb_l_control_pipe;

    typedef struct {
        logic [15:0] w;
        logic [63:0] oh_a;
        logic        ill_a;
        logic [63:0] oh_b;
        logic        ill_b;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready;
    logic [15:0] in_d;

    logic        in_ready_a, out_valid_a, out_illegal_a, mism_a;
    logic [15:0] out_instr_a, decode_count_a;
    logic [31:0] out_onehot_a;

    logic        in_ready_b, out_valid_b, out_illegal_b, mism_b;
    logic [15:0] out_instr_b;
    logic [3:0]  decode_count_b;
    logic [27:0] out_onehot_b;

    int   total = 0;
    int   bad   = 0;
    int   rmode = 1;
    exp_t q[$];

    always #5 clk = ~clk;

    l_control_pipe dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a), .in(in_d),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_instr(out_instr_a),
        .out_onehot(out_onehot_a), .out_illegal(out_illegal_a),
        .decode_count(decode_count_a), .decode_mismatch(mism_a)
    );

    l_control_pipe #(.NOPS(28), .CW(4)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b), .in(in_d),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_instr(out_instr_b),
        .out_onehot(out_onehot_b), .out_illegal(out_illegal_b),
        .decode_count(decode_count_b), .decode_mismatch(mism_b)
    );

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference decode: opcode is bits 15:11, legal opcodes select bit op, others flag illegal.
    function automatic logic [63:0] model_oh(logic [15:0] w, int n);
        int op;
        op = int'(w[15:11]);
        return (op < n) ? (64'd1 << op) : 64'd0;
    endfunction

    function automatic logic model_ill(logic [15:0] w, int n);
        return int'(w[15:11]) >= n;
    endfunction

    always @(negedge clk) begin
        if (rmode == 2) out_ready = ($urandom % 2) == 1;
        else            out_ready = (rmode == 1);
    end

    task automatic send(input logic [15:0] w);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_d     = w;
        #1;
        while (!in_ready_a) begin
            guard++;
            if (guard > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: in_ready stuck low for word %0h", w);
                return;
            end
            @(negedge clk);
            #1;
        end
        e.w     = w;
        e.oh_a  = model_oh(w, 32);
        e.ill_a = model_ill(w, 32);
        e.oh_b  = model_oh(w, 28);
        e.ill_b = model_ill(w, 28);
        q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: occupancy model predicts valid/ready; queue predicts order and content.
    int          occ = 0;
    int          cnt = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_instr;
    logic [31:0] prev_oh;
    always begin
        @(negedge clk);
        #2;
        if (reset) begin
            q.delete();
            occ = 0;
            cnt = 0;
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_a", in_ready_a, occ < 2);
            chk("in_ready_b", in_ready_b, occ < 2);
            chk("out_valid_a", out_valid_a, occ > 0);
            chk("out_valid_b", out_valid_b, occ > 0);
            chk("count_a", decode_count_a, cnt % 65536);
            chk("count_b", decode_count_b, cnt % 16);
            chk("mismatch_a", mism_a, 0);
            chk("mismatch_b", mism_b, 0);
            if (prev_stall) begin
                chk("stable_instr", out_instr_a, prev_instr);
                chk("stable_onehot", out_onehot_a, prev_oh);
            end
            if (out_valid_a && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h expected none", out_instr_a);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("instr_a", out_instr_a, e.w);
                    chk("onehot_a", out_onehot_a, e.oh_a);
                    chk("illegal_a", out_illegal_a, e.ill_a);
                    chk("instr_b", out_instr_b, e.w);
                    chk("onehot_b", out_onehot_b, e.oh_b);
                    chk("illegal_b", out_illegal_b, e.ill_b);
                end
            end
            prev_stall = out_valid_a && !out_ready;
            prev_instr = out_instr_a;
            prev_oh    = out_onehot_a;
            if (in_valid && in_ready_a) begin
                occ++;
                cnt++;
            end
            if (out_valid_a && out_ready) occ--;
        end
    end

    initial begin
        int guard;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_d     = '0;
        rmode    = 1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_instr", out_instr_a, 0);
        chk("rst_onehot", out_onehot_a, 0);
        chk("rst_illegal", out_illegal_a, 0);

        // Directed stream, including op 31 which is illegal for the NOPS=28 instance
        send(16'h0199);
        send(16'h0999);
        send(16'h1000);
        send(16'hF800);
        idle();
        repeat (3) idle();

        // Back-pressure: two words fill the pipe, the third waits for out_ready
        rmode = 0;
        send(16'h2345);
        send(16'hE001);
        fork
            send(16'h7777);
            begin
                repeat (6) @(negedge clk);
                rmode = 1;
            end
        join
        idle();
        repeat (3) idle();

        // Reset while both entries are occupied
        rmode = 0;
        send(16'h4444);
        send(16'h5555);
        idle();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rmode = 1;
        repeat (4) idle();

        // Randomized stream with random back-pressure and gaps
        rmode = 2;
        for (int i = 0; i < 600; i++) begin
            if (($urandom % 4) == 0) idle();
            send(16'($urandom));
        end
        idle();

        rmode = 1;
        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        chk("drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l_control_pipe.md
Name: l_control_pipe

Overview:
- Pipelined, parametrised successor to the combinational L_Control instruction decoder.
- Accepts instruction words over a valid/ready handshake and decodes the opcode field into a NOPS-wide one-hot control vector, with an illegal-opcode flag.
- Presents the instruction and its decode to the execute stage through a registered output with a 2-entry skid buffer.
- Sits between instruction fetch and execute; keeps a running count of decoded instructions.

Parameters:
- IW, 16: instruction width in bits.
- OPW, 5: opcode field width.
- OP_LSB, 11: bit position of the opcode field LSB. Field is in[OP_LSB+OPW-1 : OP_LSB]; OP_LSB+OPW <= IW is required.
- NOPS, 32: number of legal opcodes and width of the one-hot vector; 1 <= NOPS <= 2**OPW.
- CW, 16: decode counter width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  block can accept an instruction this cycle
- in  in  IW  instruction word
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  downstream accepts the output this cycle
- out_instr  out  IW  instruction word, passed through unchanged
- out_onehot  out  NOPS  bit k set iff opcode == k
- out_illegal  out  1  opcode >= NOPS
- decode_count  out  CW  number of instructions accepted at the input
- decode_mismatch  out  1  sticky redundancy-check error (see Optional Feature)

Behaviour:
- One clock domain; all state updates on the rising edge of clk. Reset is synchronous, active-high, and overrides every other event in that cycle.
- Reset values: out_valid=0, out_instr=0, out_onehot=0, out_illegal=0, decode_count=0, decode_mismatch=0, skid buffer empty. in_ready=1 in the cycle after reset deasserts.
- Decode is combinational on `in` and is captured together with the instruction.
  - Legal opcode (op < NOPS): out_onehot = 1<<op, out_illegal=0.
  - Illegal opcode (op >= NOPS): out_onehot all zeros, out_illegal=1.
- Input handshake: an instruction is accepted when in_valid && in_ready. Output handshake: a transfer occurs when out_valid && out_ready.
- in_ready is driven directly from a register: in_ready = !skid_full. It does not depend combinationally on out_ready.
- State machine:
  - EMPTY: output register and skid both empty.
    - accept -> ONE; output register loaded; out_valid=1 next cycle. Latency is 1 cycle.
  - ONE: output register holds data, skid empty.
    - accept with transfer -> ONE; output register reloaded with the new instruction.
    - accept without transfer -> TWO; new instruction goes into skid.
    - transfer without accept -> EMPTY.
    - neither -> ONE; output held.
  - TWO: both output register and skid full; in_ready=0.
    - transfer -> ONE; skid moves into the output register.
    - no transfer -> TWO; all held.
- Ordering: strict FIFO, no drops, no duplicates.
- Output stability: while out_valid && !out_ready, out_instr, out_onehot and out_illegal must not change.
- decode_count increments by 1 on every input acceptance, illegal opcodes included. It wraps modulo 2**CW.
- Reset mid-operation discards both buffered entries. No output transfer occurs in the reset cycle.

Optional Feature:
- Macro: L_CONTROL_PIPE_DUAL_DECODE_EN.
- When defined:
  - A second, independently coded decoder (comparator chain instead of shift) runs on the same input.
  - Its result is compared with the primary decode at input capture.
  - Any difference sets decode_mismatch=1, which stays set until reset.
- When not defined: decode_mismatch is tied to 0 and the second decoder is not instantiated.

Test Plan:
- Defaults; reset held 2 cycles, then in=16'h0199 (op=0) with in_valid=1, out_ready=1 -> one cycle later out_valid=1, out_onehot=32'h00000001, out_illegal=0, decode_count=1.
- Stream 16'h0999 (op=1), 16'h1000 (op=2), 16'hF800 (op=31) back-to-back with out_ready=1 -> onehots 0x2, 0x4, 0x80000000 on consecutive cycles; in_ready stays 1 throughout.
- NOPS=28, in=16'hF800 (op=31) -> out_illegal=1, out_onehot=0; decode_count still increments.
- Hold out_ready=0 and offer 3 words -> first two accepted, in_ready=0 on cycle 3, outputs stable. Then raise out_ready -> words emerge in order, in_ready=1 one cycle after the first transfer.
- Assert reset while in state TWO -> next cycle out_valid=0, in_ready=1, decode_count=0, and no stale word appears afterwards.
- CW=4 with 17 accepted instructions -> decode_count reads 1. With macro defined, random 1000-word stream -> decode_mismatch stays 0.
